viterbi_tb_ctrl: RTL

Traceback controller that sits on the other side of the 64x64 survivor SRAM (64 states, K=7). It accepts one 64-bit survivor-decision word per trellis step from the ACS unit and writes the frame into the SRAM. It then reads the words back in reverse and traces the survivor path from a given end state. Decoded bits are emitted in forward order over a valid/ready stream. Single frame buffer: frames do not overlap.

---
 rtl/viterbi_tb_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/viterbi_tb_ctrl.sv
// Viterbi traceback controller: buffers one frame of survivor decisions in an
// external SRAM, traces back from the given end state, streams bits in order.
module viterbi_tb_ctrl #(
  parameter int BLK_LEN = 64,
  parameter int ADDR_W  = 6,
  parameter int ST_W    = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   dec_valid_i,
  output logic                   dec_ready_o,
  input  logic [(1<<ST_W)-1:0]   dec_word_i,
  input  logic [ST_W-1:0]        start_state_i,
  output logic                   wr_en_o,
  output logic                   rd_en_o,
  output logic [ADDR_W-1:0]      addr_o,
  output logic [(1<<ST_W)-1:0]   wdata_o,
  input  logic [(1<<ST_W)-1:0]   rdata_i,
  output logic                   bit_o,
  output logic                   bit_valid_o,
  input  logic                   bit_ready_i,
  output logic                   bit_last_o,
  output logic                   busy_o
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(BLK_LEN - 1);

  typedef enum logic [2:0] {
    S_WRITE,
    S_FLUSH,
    S_TB_RD,
    S_TB_WAIT,
    S_OUT
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0]      wcnt, tcnt, ocnt;
  logic [ST_W-1:0]        cur_state;
  logic [(1<<ADDR_W)-1:0] lifo;
  logic                   dec_hs, out_hs;

  assign dec_hs = dec_valid_i & dec_ready_o;
  assign out_hs = bit_valid_o & bit_ready_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= S_WRITE;
    else          state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first, so no path through the case can infer a latch.
    state_nxt = state;
    unique case (state)
      S_WRITE:   if (dec_hs && wcnt == LAST) state_nxt = S_FLUSH;
      S_FLUSH:   state_nxt = S_TB_RD;
      S_TB_RD:   state_nxt = S_TB_WAIT;
      S_TB_WAIT: state_nxt = (tcnt == '0) ? S_OUT : S_TB_RD;
      S_OUT:     if (out_hs && ocnt == LAST) state_nxt = S_WRITE;
      default:   state_nxt = S_WRITE;
    endcase
  end

  always_comb begin
    dec_ready_o = (state == S_WRITE);
    busy_o      = (state != S_WRITE);
    bit_valid_o = (state == S_OUT);
    bit_last_o  = (state == S_OUT) && (ocnt == LAST);
    bit_o       = lifo[ocnt];
  end

  // Counters, survivor state and the registered SRAM port.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wcnt      <= '0;
      tcnt      <= '0;
      ocnt      <= '0;
      cur_state <= '0;
      wr_en_o   <= 1'b0;
      rd_en_o   <= 1'b0;
      addr_o    <= '0;
      wdata_o   <= '0;
    end else begin
      // NOTE: non-blocking assignments, so every register here sees pre-edge values.
      wr_en_o <= 1'b0;
      rd_en_o <= 1'b0;
      unique case (state)
        S_WRITE: begin
          if (dec_hs) begin
            wr_en_o <= 1'b1;
            addr_o  <= wcnt;
            wdata_o <= dec_word_i;
            if (wcnt == LAST) begin
              cur_state <= start_state_i;
              tcnt      <= LAST;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        S_FLUSH: begin
          rd_en_o <= 1'b1;
          addr_o  <= tcnt;
        end
        S_TB_RD: ;
        S_TB_WAIT: begin
          // Undo next = {prev[4:0], u}: the stored decision restores prev's MSB.
          cur_state <= {rdata_i[cur_state], cur_state[ST_W-1:1]};
          if (tcnt == '0) begin
            ocnt <= '0;
          end else begin
            tcnt    <= tcnt - 1'b1;
            rd_en_o <= 1'b1;
            addr_o  <= tcnt - 1'b1;
          end
        end
        S_OUT: begin
          if (out_hs) begin
            if (ocnt == LAST) wcnt <= '0;
            else              ocnt <= ocnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the LIFO has no reset; every entry is rewritten during traceback before S_OUT reads it.
  always_ff @(posedge clk_i) begin
    if (state == S_TB_WAIT) lifo[tcnt] <= cur_state[0];
  end

endmodule
